// File: rtl/ahb_decoder_mux_sn_if.sv
// rtl/ahb_decoder_mux_sn_if.sv - AHB decoder/mux bus bundle: address phase, slave responses, shared response, error capture
interface ahb_decoder_mux_sn_if #(
    parameter int P_NUM   = 3,
    parameter int P_DW    = 32,
    parameter int P_CNT_W = 8
);
    logic [31:0]           haddr;
    logic [1:0]            htrans;
    logic                  remap;
    logic [P_NUM-1:0]      hsel;
    logic                  hseld;
    logic [P_NUM*P_DW-1:0] hrdata_s;
    logic [P_NUM-1:0]      hreadyout_s;
    logic [2*P_NUM-1:0]    hresp_s;
    logic [P_DW-1:0]       hrdata;
    logic                  hready;
    logic [1:0]            hresp;
    logic [31:0]           err_addr;
    logic [P_CNT_W-1:0]    err_cnt;

    modport slave (
        input  haddr, htrans, remap, hrdata_s, hreadyout_s, hresp_s,
        output hsel, hseld, hrdata, hready, hresp, err_addr, err_cnt
    );

    modport master (
        output haddr, htrans, remap, hrdata_s, hreadyout_s, hresp_s,
        input  hsel, hseld, hrdata, hready, hresp, err_addr, err_cnt
    );
endinterface

// File: rtl/ahb_decoder_mux_sn.sv
// rtl/ahb_decoder_mux_sn.sv - AHB address decoder, data-phase response mux and built-in ERROR default slave
module ahb_decoder_mux_sn #(
    parameter int                    P_NUM        = 3,
    parameter int                    P_DW         = 32,
    parameter logic [16*P_NUM-1:0]   P_ADDR_START = {16'h0020, 16'h0010, 16'h0000},
    parameter logic [16*P_NUM-1:0]   P_ADDR_SIZE  = {16'h0010, 16'h0010, 16'h0010},
    parameter int                    P_CNT_W      = 8
) (
    input  logic                hclk,
    input  logic                hreset,
    ahb_decoder_mux_sn_if.slave bus
);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_t;

    state_t             state;
    logic               def_ready;
    logic [1:0]         def_resp;
    logic [P_NUM:0]     sel_q;
    logic [P_NUM-1:0]   hit_raw;
    logic [P_NUM-1:0]   hit_sw;
    logic [P_NUM-1:0]   hsel_c;
    logic               hseld_c;
    logic               hready_c;
    logic               err_enter;
    logic [15:0]        a;

    // End bound is formed in 17 bits so a region reaching 16'hFFFF does not wrap.
    always_comb begin
        a = bus.haddr[31:16];
        for (int i = 0; i < P_NUM; i++) begin
            hit_raw[i] = (P_ADDR_SIZE[16*i +: 16] != 16'd0)
                      && (a >= P_ADDR_START[16*i +: 16])
                      && ({1'b0, a} <= ({1'b0, P_ADDR_START[16*i +: 16]}
                                       + {1'b0, P_ADDR_SIZE[16*i +: 16]} - 17'd1));
        end
    end

    generate
        if (P_NUM >= 2) begin : g_remap
            always_comb begin
                hit_sw = hit_raw;
                if (bus.remap) begin
                    hit_sw[0] = hit_raw[1];
                    hit_sw[1] = hit_raw[0];
                end
            end
        end else begin : g_no_remap
            assign hit_sw = hit_raw;
        end
    endgenerate

    // Lowest index wins on overlap, keeping hsel one-hot or zero.
    always_comb begin
        hsel_c = '0;
        for (int i = P_NUM - 1; i >= 0; i--) begin
            if (hit_sw[i]) begin
                hsel_c    = '0;
                hsel_c[i] = 1'b1;
            end
        end
        hseld_c = ~|hit_sw;
    end

    always_comb begin
        bus.hrdata = '0;
        hready_c   = def_ready;
        bus.hresp  = def_resp;
        for (int i = 0; i < P_NUM; i++) begin
            if (sel_q[i]) begin
                bus.hrdata = bus.hrdata_s[i*P_DW +: P_DW];
                hready_c   = bus.hreadyout_s[i];
                bus.hresp  = bus.hresp_s[2*i +: 2];
            end
        end
    end

    assign bus.hsel   = hsel_c;
    assign bus.hseld  = hseld_c;
    assign bus.hready = hready_c;

    // ERR1 always holds the bus, so a new unmapped NONSEQ/SEQ is only accepted from IDLE or ERR2.
    assign err_enter = hready_c && hseld_c && bus.htrans[1] && (state != S_ERR1);

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state        <= S_IDLE;
            def_ready    <= 1'b1;
            def_resp     <= RESP_OKAY;
            sel_q        <= {1'b1, {P_NUM{1'b0}}};
            bus.err_addr <= '0;
            bus.err_cnt  <= '0;
        end else begin
            if (hready_c) begin
                sel_q <= {hseld_c, hsel_c};
            end
            if (err_enter) begin
                state        <= S_ERR1;
                def_ready    <= 1'b0;
                def_resp     <= RESP_ERROR;
                bus.err_addr <= bus.haddr;
                if (bus.err_cnt != {P_CNT_W{1'b1}}) begin
                    bus.err_cnt <= bus.err_cnt + 1'b1;
                end
            end else if (state == S_ERR1) begin
                state     <= S_ERR2;
                def_ready <= 1'b1;
                def_resp  <= RESP_ERROR;
            end else begin
                state     <= S_IDLE;
                def_ready <= 1'b1;
                def_resp  <= RESP_OKAY;
            end
        end
    end
endmodule

// File: tb/tb_ahb_decoder_mux_sn.sv
// tb/tb_ahb_decoder_mux_sn.sv - self-checking bench for ahb_decoder_mux_sn
module tb_ahb_decoder_mux_sn;
    localparam int          P_NUM = 3;
    localparam int          P_DW  = 32;
    localparam logic [31:0] D0 = 32'hAAAA_0000;
    localparam logic [31:0] D1 = 32'hBBBB_0001;
    localparam logic [31:0] D2 = 32'hCCCC_0002;
    localparam logic [1:0]  T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;

    logic hclk = 1'b0;
    logic hreset;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 hclk = ~hclk;

    ahb_decoder_mux_sn_if #(.P_NUM(P_NUM), .P_DW(P_DW), .P_CNT_W(8)) bus ();

    ahb_decoder_mux_sn #(.P_NUM(P_NUM), .P_DW(P_DW), .P_CNT_W(8)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        remap;
        logic [3:0]  exp_sel;
    } dec_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        remap;
        int          tgt;
    } stream_t;

    typedef struct {
        logic [31:0] rdata;
        logic        ready;
        logic [1:0]  resp;
    } dexp_t;

    dec_t    dec_tab[9];
    stream_t str_tab[8];
    dexp_t   sb_q[$];
    dexp_t   e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    function automatic dexp_t data_exp(input int tgt);
        dexp_t r;
        r.ready = 1'b1;
        case (tgt)
            0:       begin r.rdata = D0; r.resp = 2'b00; end
            1:       begin r.rdata = D1; r.resp = 2'b01; end
            2:       begin r.rdata = D2; r.resp = 2'b00; end
            default: begin r.rdata = 32'h0; r.resp = 2'b00; end
        endcase
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        dec_tab[0] = '{32'h0010_0004, 1'b0, 4'b0010};
        dec_tab[1] = '{32'h0000_0000, 1'b1, 4'b0010};
        dec_tab[2] = '{32'h0000_0000, 1'b0, 4'b0001};
        dec_tab[3] = '{32'h000F_FFFF, 1'b0, 4'b0001};
        dec_tab[4] = '{32'h0010_0000, 1'b1, 4'b0001};
        dec_tab[5] = '{32'h002F_FFFC, 1'b0, 4'b0100};
        dec_tab[6] = '{32'h0030_0000, 1'b0, 4'b1000};
        dec_tab[7] = '{32'hFFFF_0000, 1'b0, 4'b1000};
        dec_tab[8] = '{32'h0040_0000, 1'b0, 4'b1000};

        str_tab[0] = '{32'h0010_0004, T_NSEQ, 1'b0, 1};
        str_tab[1] = '{32'h0000_0010, T_SEQ,  1'b0, 0};
        str_tab[2] = '{32'h0020_0008, T_NSEQ, 1'b0, 2};
        str_tab[3] = '{32'h0000_0000, T_NSEQ, 1'b1, 1};
        str_tab[4] = '{32'h0010_0000, T_NSEQ, 1'b1, 0};
        str_tab[5] = '{32'h0040_0000, T_IDLE, 1'b0, 3};
        str_tab[6] = '{32'h002F_FFFC, T_SEQ,  1'b0, 2};
        str_tab[7] = '{32'h0030_0000, T_BUSY, 1'b0, 3};

        bus.haddr       = 32'h0;
        bus.htrans      = T_IDLE;
        bus.remap       = 1'b0;
        bus.hrdata_s    = {D2, D1, D0};
        bus.hreadyout_s = 3'b111;
        bus.hresp_s     = {2'b00, 2'b01, 2'b00};
        hreset          = 1'b1;
        tick();
        tick();
        hreset = 1'b0;
        #1;
        chk("rst_hready",   64'(bus.hready),   64'(1));
        chk("rst_hresp",    64'(bus.hresp),    64'(0));
        chk("rst_hrdata",   64'(bus.hrdata),   64'(0));
        chk("rst_err_addr", 64'(bus.err_addr), 64'(0));
        chk("rst_err_cnt",  64'(bus.err_cnt),  64'(0));

        for (int i = 0; i < 9; i++) begin
            bus.haddr = dec_tab[i].addr;
            bus.remap = dec_tab[i].remap;
            #1;
            chk($sformatf("dec%0d_sel", i), 64'({bus.hseld, bus.hsel}), 64'(dec_tab[i].exp_sel));
        end
        bus.remap = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            bus.haddr  = str_tab[i].addr;
            bus.htrans = str_tab[i].trans;
            bus.remap  = str_tab[i].remap;
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk($sformatf("str%0d_hrdata", i), 64'(bus.hrdata), 64'(e.rdata));
                chk($sformatf("str%0d_hready", i), 64'(bus.hready), 64'(e.ready));
                chk($sformatf("str%0d_hresp", i),  64'(bus.hresp),  64'(e.resp));
            end
            sb_q.push_back(data_exp(str_tab[i].tgt));
            tick();
        end
        bus.haddr  = 32'h0040_0000;
        bus.htrans = T_IDLE;
        bus.remap  = 1'b0;
        #1;
        e = sb_q.pop_front();
        chk("str_last_hrdata", 64'(bus.hrdata), 64'(e.rdata));
        chk("str_last_hready", 64'(bus.hready), 64'(e.ready));
        chk("str_last_hresp",  64'(bus.hresp),  64'(e.resp));
        tick();

        bus.haddr  = 32'h0040_0000;
        bus.htrans = T_NSEQ;
        #1;
        chk("err_ap_hseld",  64'(bus.hseld),  64'(1));
        chk("err_ap_hready", 64'(bus.hready), 64'(1));
        tick();
        bus.htrans = T_IDLE;
        bus.haddr  = 32'h0;
        #1;
        chk("err1_hready", 64'(bus.hready), 64'(0));
        chk("err1_hresp",  64'(bus.hresp),  64'(1));
        chk("err1_hrdata", 64'(bus.hrdata), 64'(0));
        tick();
        #1;
        chk("err2_hready",   64'(bus.hready),   64'(1));
        chk("err2_hresp",    64'(bus.hresp),    64'(1));
        chk("err_addr_1",    64'(bus.err_addr), 64'h0040_0000);
        chk("err_cnt_1",     64'(bus.err_cnt),  64'(1));
        tick();
        #1;
        chk("err_done_hresp", 64'(bus.hresp), 64'(0));

        bus.haddr  = 32'h0050_0000;
        bus.htrans = T_NSEQ;
        tick();
        #1;
        chk("b2b_a_err1_hready", 64'(bus.hready), 64'(0));
        tick();
        bus.haddr = 32'h0060_0000;
        #1;
        chk("b2b_a_err2_hready", 64'(bus.hready), 64'(1));
        chk("b2b_a_err2_hresp",  64'(bus.hresp),  64'(1));
        tick();
        bus.htrans = T_IDLE;
        #1;
        chk("b2b_b_err1_hready", 64'(bus.hready),   64'(0));
        chk("b2b_b_err1_hresp",  64'(bus.hresp),    64'(1));
        chk("b2b_err_addr",      64'(bus.err_addr), 64'h0060_0000);
        chk("b2b_err_cnt",       64'(bus.err_cnt),  64'(3));
        tick();
        tick();
        #1;
        chk("b2b_end_hready", 64'(bus.hready), 64'(1));
        chk("b2b_end_hresp",  64'(bus.hresp),  64'(0));

        bus.haddr  = 32'h0040_0000;
        bus.htrans = T_IDLE;
        tick();
        #1;
        chk("idle_unmapped_hready", 64'(bus.hready), 64'(1));
        chk("idle_unmapped_hresp",  64'(bus.hresp),  64'(0));
        bus.htrans = T_BUSY;
        tick();
        #1;
        chk("busy_unmapped_hready", 64'(bus.hready),  64'(1));
        chk("busy_unmapped_hresp",  64'(bus.hresp),   64'(0));
        chk("busy_unmapped_cnt",    64'(bus.err_cnt), 64'(3));

        bus.haddr  = 32'h0020_0000;
        bus.htrans = T_NSEQ;
        tick();
        bus.hreadyout_s[2] = 1'b0;
        bus.haddr          = 32'h0000_0000;
        #1;
        chk("wait0_hready", 64'(bus.hready), 64'(0));
        tick();
        bus.haddr = 32'h0040_0000;
        #1;
        chk("wait1_hready", 64'(bus.hready), 64'(0));
        tick();
        bus.haddr = 32'h0000_0000;
        #1;
        chk("wait2_hready", 64'(bus.hready), 64'(0));
        tick();
        bus.hreadyout_s[2] = 1'b1;
        #1;
        chk("wait_end_hready", 64'(bus.hready), 64'(1));
        chk("wait_end_hrdata", 64'(bus.hrdata), 64'(D2));
        tick();
        bus.htrans = T_IDLE;
        #1;
        chk("after_wait_hrdata", 64'(bus.hrdata),  64'(D0));
        chk("after_wait_cnt",    64'(bus.err_cnt), 64'(3));
        tick();

        bus.haddr  = 32'h0040_0000;
        bus.htrans = T_NSEQ;
        tick();
        #1;
        chk("rst_mid_err1_hready", 64'(bus.hready), 64'(0));
        hreset = 1'b1;
        tick();
        hreset     = 1'b0;
        bus.htrans = T_IDLE;
        #1;
        chk("rst_mid_hready",   64'(bus.hready),   64'(1));
        chk("rst_mid_hresp",    64'(bus.hresp),    64'(0));
        chk("rst_mid_err_cnt",  64'(bus.err_cnt),  64'(0));
        chk("rst_mid_err_addr", 64'(bus.err_addr), 64'(0));

        bus.htrans = T_NSEQ;
        for (int n = 0; n < 508; n++) tick();
        #1;
        chk("sat_cnt_254", 64'(bus.err_cnt), 64'h0FE);
        for (int n = 0; n < 2; n++) tick();
        #1;
        chk("sat_cnt_255", 64'(bus.err_cnt), 64'h0FF);
        for (int n = 0; n < 90; n++) tick();
        #1;
        chk("sat_cnt_300", 64'(bus.err_cnt), 64'h0FF);
        bus.htrans = T_IDLE;
        tick();
        tick();
        #1;
        chk("sat_end_hready", 64'(bus.hready), 64'(1));
        chk("sat_end_hresp",  64'(bus.hresp),  64'(0));
        chk("sb_empty",       64'(sb_q.size()), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
